// File: rtl/multdiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states, counter sizing.
package multdiv_pkg;

   localparam int unsigned DEF_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_DIV   = 2'b01,
      OP_MULTU = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Step counter must hold 0..WIDTH-1
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/div_core.sv
// Restoring divider datapath: one shift-subtract step per cycle on operand magnitudes,
// with the quotient/remainder sign fix-up applied to the post-step values.
module div_core
   import multdiv_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             sgn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] quo_c,
   output logic [WIDTH-1:0] rem_c
);

   logic [WIDTH-1:0] rem, quo, dvs, rem_nx, quo_nx;
   logic [WIDTH:0]   r_sh, diff;
   logic             neg_q, neg_r, ge;

   assign r_sh   = {rem, quo[WIDTH-1]};
   assign diff   = r_sh - {1'b0, dvs};
   assign ge     = ~diff[WIDTH];
   assign rem_nx = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
   assign quo_nx = {quo[WIDTH-2:0], ge};

   // Quotient truncates toward zero; remainder follows the dividend's sign
   assign quo_c = neg_q ? WIDTH'(0) - quo_nx : quo_nx;
   assign rem_c = neg_r ? WIDTH'(0) - rem_nx : rem_nx;

   always_ff @(posedge clk) begin
      if (!reset) begin
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (load) begin
         rem   <= '0;
         quo   <= (sgn && a[WIDTH-1]) ? WIDTH'(0) - a : a;
         dvs   <= (sgn && b[WIDTH-1]) ? WIDTH'(0) - b : b;
         neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
         neg_r <= sgn && a[WIDTH-1];
      end else if (step) begin
         rem   <= rem_nx;
         quo   <= quo_nx;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU (radix-2 Booth) and DIV/DIVU unit with HI/LO result registers.
// Divider is built only when MULTDIV_DIV_EN is defined; otherwise DIV/DIVU finish as unsupported ops.
module mult_div_unit
   import multdiv_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_e           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic             accept, last, op_is_div, op_signed, bypass;
   logic             busy_d, done_d, div_zero_d;
   logic [WIDTH-1:0] hi_d, lo_d;

   logic [WIDTH:0]   acc, mcand, acc_nx;
   logic [WIDTH+1:0] sum;
   logic [WIDTH-1:0] q, q_nx, hi_mul;
   logic             q_m1, ucorr;

   assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);
   assign op_signed = (op == OP_MULT) || (op == OP_DIV);
   assign accept    = (state == ST_IDLE) && start;
   assign last      = (state == ST_RUN) && (cnt == CW'(WIDTH - 1));

`ifdef MULTDIV_DIV_EN
   logic             is_div, dz_pend;
   logic [WIDTH-1:0] quo_res, rem_res;

   assign bypass = op_is_div && (b_in == '0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         is_div  <= 1'b0;
         dz_pend <= 1'b0;
      end else if (accept) begin
         is_div  <= op_is_div;
         dz_pend <= bypass;
      end else if (state == ST_DONE) begin
         dz_pend <= 1'b0;
      end
   end

   div_core #(.WIDTH(WIDTH)) u_div_core (
      .clk   (clk),
      .reset (reset),
      .load  (accept && op_is_div && !bypass),
      .step  ((state == ST_RUN) && is_div),
      .sgn   (op_signed),
      .a     (a_in),
      .b     (b_in),
      .quo_c (quo_res),
      .rem_c (rem_res)
   );
`else
   assign bypass = op_is_div;
`endif

   // Booth step on a WIDTH+1 multiplicand; the extra sum bit absorbs add/sub growth before the shift
   always_comb begin
      sum = {acc[WIDTH], acc};
      case ({q[0], q_m1})
         2'b10:   sum = {acc[WIDTH], acc} - {mcand[WIDTH], mcand};
         2'b01:   sum = {acc[WIDTH], acc} + {mcand[WIDTH], mcand};
         default: sum = {acc[WIDTH], acc};
      endcase
   end

   assign acc_nx = sum[WIDTH+1:1];
   assign q_nx   = {sum[0], q[WIDTH-1:1]};
   // Booth reads the multiplier as signed; an unsigned multiplier with MSB set needs +A<<WIDTH
   assign hi_mul = acc_nx[WIDTH-1:0] + (ucorr ? mcand[WIDTH-1:0] : WIDTH'(0));

   always_ff @(posedge clk) begin
      if (!reset) begin
         acc   <= '0;
         mcand <= '0;
         q     <= '0;
         q_m1  <= 1'b0;
         ucorr <= 1'b0;
      end else if (accept) begin
         acc   <= '0;
         mcand <= {op_signed & a_in[WIDTH-1], a_in};
         q     <= b_in;
         q_m1  <= 1'b0;
         ucorr <= ~op_signed & b_in[WIDTH-1];
      end else if (state == ST_RUN) begin
         acc   <= acc_nx;
         q     <= q_nx;
         q_m1  <= q[0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = bypass ? ST_DONE : ST_RUN;
         ST_RUN:  if (last)  state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_d     = (state_nxt != ST_IDLE);
      done_d     = 1'b0;
      div_zero_d = 1'b0;
      hi_d       = hi_out;
      lo_d       = lo_out;
      if (last) begin
         done_d = 1'b1;
         hi_d   = hi_mul;
         lo_d   = q_nx;
`ifdef MULTDIV_DIV_EN
         if (is_div) begin
            hi_d = rem_res;
            lo_d = quo_res;
         end
`endif
      end
`ifdef MULTDIV_DIV_EN
      if ((state == ST_DONE) && dz_pend) begin
         done_d     = 1'b1;
         div_zero_d = 1'b1;
      end
`else
      if (accept && bypass) begin
         done_d     = 1'b1;
         div_zero_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi_out   <= '0;
         lo_out   <= '0;
         cnt      <= '0;
      end else begin
         busy     <= busy_d;
         done     <= done_d;
         div_zero <= div_zero_d;
         hi_out   <= hi_d;
         lo_out   <= lo_d;
         if (accept)                cnt <= '0;
         else if (state == ST_RUN)  cnt <= cnt + CW'(1);
      end
   end

endmodule
